// File: rtl/bp_trace_sequencer_if.sv
// Record stream and predictor pin bundle for bp_trace_sequencer.
// master: trace source / predictor side. slave: the sequencer.
interface bp_trace_sequencer_if;
  // record stream from the trace source
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_addr;
  logic       in_taken;
  // predictor pins
  logic       bp_mem_reset_done;
  logic       bp_pred_ready;
  logic       bp_prediction;
  logic       bp_training_done;
  logic [7:0] bp_inst_addr;
  logic       bp_new_data;
  logic       bp_truth;

  modport master (
    output in_valid, in_addr, in_taken,
    output bp_mem_reset_done, bp_pred_ready, bp_prediction, bp_training_done,
    input  in_ready, bp_inst_addr, bp_new_data, bp_truth
  );

  modport slave (
    input  in_valid, in_addr, in_taken,
    input  bp_mem_reset_done, bp_pred_ready, bp_prediction, bp_training_done,
    output in_ready, bp_inst_addr, bp_new_data, bp_truth
  );
endinterface

// File: rtl/bp_trace_sequencer.sv
// bp_trace_sequencer: buffers branch records in a small FIFO, issues them one
// at a time to the perceptron predictor and scores the returned predictions.
// Optional watchdog on a stuck predictor: define BP_SEQ_TIMEOUT_EN.
module bp_trace_sequencer #(
  parameter int DEPTH          = 4,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bp_trace_sequencer_if.slave   bus,
  input  logic                  stats_clr_i,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      total_cnt_o,
  output logic [CNT_W-1:0]      mispred_cnt_o,
  output logic                  timeout_err_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOAD, S_ACTIVE} state_e;

  state_e           state_q;
  logic [8:0]       mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             empty_w, full_w, push_w, pop_w;
  logic [7:0]       addr_q;
  logic             truth_q, nd_q, busy_q, mis_q;
  logic             done_w, mis_now_w, tmo_w;
  logic [CNT_W-1:0] tot_q, tot_d, mcnt_q, mcnt_d;

  // FIFO status; extra pointer bit separates full from empty
  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_w  = bus.in_valid && bus.in_ready;
  assign pop_w   = (state_q == S_IDLE) && !empty_w;

  // in_ready is held low while reset is asserted
  assign bus.in_ready = rst_n && !full_w;

  // FIFO storage, data needs no reset
  always_ff @(posedge clk) begin
    if (push_w) mem_q[wr_ptr_q[AW-1:0]] <= {bus.in_addr, bus.in_taken};
  end

  // FIFO pointers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // completion and mispredict for the current cycle; a same-cycle pred_ready
  // overrides the latched value so the no-training case scores correctly
  assign done_w    = (state_q == S_ACTIVE) && bus.bp_training_done;
  assign mis_now_w = bus.bp_pred_ready ? (bus.bp_prediction != truth_q) : mis_q;

  // issue FSM with registered predictor-side outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      addr_q  <= '0;
      truth_q <= 1'b0;
      nd_q    <= 1'b0;
      busy_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          if (bus.bp_mem_reset_done) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (!empty_w) begin
            {addr_q, truth_q} <= mem_q[rd_ptr_q[AW-1:0]];
            mis_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          // address/truth settled for a cycle; now raise new_data
          nd_q    <= 1'b1;
          state_q <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (bus.bp_pred_ready) mis_q <= mis_now_w;
          if (done_w || tmo_w) begin
            nd_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

`ifdef BP_SEQ_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             terr_q;

  // last allowed ACTIVE cycle without training_done aborts the record
  assign tmo_w = (state_q == S_ACTIVE) && !bus.bp_training_done &&
                 (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // ACTIVE cycle counter and sticky error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      terr_q    <= 1'b0;
    end else begin
      tmo_cnt_q <= (state_q == S_ACTIVE) ? tmo_cnt_q + 1'b1 : '0;
      if (tmo_w) terr_q <= 1'b1;
    end
  end

  assign timeout_err_o = terr_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
  assign tmo_w          = 1'b0;
  assign timeout_err_o  = 1'b0;
`endif

  // saturating statistics; clear wins over a same-cycle completion
  always_comb begin
    tot_d  = tot_q;
    mcnt_d = mcnt_q;
    if (stats_clr_i) begin
      tot_d  = '0;
      mcnt_d = '0;
    end else if (done_w) begin
      if (tot_q != '1)                mcnt_d = mcnt_d;
      if (tot_q != '1)                tot_d  = tot_q + CNT_W'(1);
      if (mis_now_w && mcnt_q != '1)  mcnt_d = mcnt_q + CNT_W'(1);
    end
  end

  // statistics registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tot_q  <= '0;
      mcnt_q <= '0;
    end else begin
      tot_q  <= tot_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign bus.bp_inst_addr = addr_q;
  assign bus.bp_truth     = truth_q;
  assign bus.bp_new_data  = nd_q;
  assign busy_o           = busy_q;
  assign total_cnt_o      = tot_q;
  assign mispred_cnt_o    = mcnt_q;

endmodule

// File: tb/tb_bp_trace_sequencer.sv
// Scoreboard bench for bp_trace_sequencer: records are queued when accepted and
// checked when the sequencer raises new_data; counters follow a bench model.
module tb_bp_trace_sequencer;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;
  localparam int TMO   = 16;

  logic             clk, rst_n, stats_clr;
  logic             busy, terr;
  logic [CNT_W-1:0] total, mispred;

  bp_trace_sequencer_if bif();

  bp_trace_sequencer #(.DEPTH(4), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif), .stats_clr_i(stats_clr),
    .busy_o(busy), .total_cnt_o(total), .mispred_cnt_o(mispred),
    .timeout_err_o(terr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int exp_tot = 0, exp_mis = 0;
  logic [8:0] sb[$];
  logic [7:0] cur_addr;
  logic       cur_taken;
  logic       prev_nd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  // issue monitor: pop on each new_data rise, then require stable hold values
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) prev_nd <= 1'b0;
    else begin
      if (bif.bp_new_data && !prev_nd) begin
        if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          cur_addr  <= e[8:1];
          cur_taken <= e[0];
          chk("issue_addr", 32'(bif.bp_inst_addr), 32'(e[8:1]));
          chk("issue_truth", 32'(bif.bp_truth), 32'(e[0]));
        end
      end else if (bif.bp_new_data) begin
        chk("hold_addr", 32'(bif.bp_inst_addr), 32'(cur_addr));
        chk("hold_truth", 32'(bif.bp_truth), 32'(cur_taken));
      end
      prev_nd <= bif.bp_new_data;
    end
  end

  task automatic push(input logic [7:0] a, input logic t);
    int n = 0;
    bif.in_valid = 1'b1; bif.in_addr = a; bif.in_taken = t;
    while (!bif.in_ready && n < 100) begin tick(); n++; end
    chk("push_ready", 32'(bif.in_ready), 32'd1);
    tick();
    sb.push_back({a, t});
    bif.in_valid = 1'b0;
  endtask

  task automatic wait_nd();
    int n = 0;
    while (!bif.bp_new_data && n < 50) begin tick(); n++; end
    chk("issue_wait", 32'(bif.bp_new_data), 32'd1);
  endtask

  task automatic drive_resp(input logic pr, input logic pred, input logic td);
    bif.bp_pred_ready = pr; bif.bp_prediction = pred; bif.bp_training_done = td;
    tick();
    bif.bp_pred_ready = 1'b0; bif.bp_training_done = 1'b0;
  endtask

  // prediction with pred_ready, training_done gap cycles later (0 = same cycle)
  task automatic respond(input logic pred, input int gap, input logic clr);
    stats_clr = clr;
    if (gap == 0) drive_resp(1'b1, pred, 1'b1);
    else begin
      drive_resp(1'b1, pred, 1'b0);
      repeat (gap - 1) tick();
      drive_resp(1'b0, 1'b0, 1'b1);
    end
    stats_clr = 1'b0;
    if (clr) begin exp_tot = 0; exp_mis = 0; end
    else begin
      exp_tot = sat(exp_tot + 1);
      if (pred != cur_taken) exp_mis = sat(exp_mis + 1);
    end
    chk("nd_drop", 32'(bif.bp_new_data), 32'd0);
    chk("total", 32'(total), 32'(exp_tot));
    chk("mispred", 32'(mispred), 32'(exp_mis));
  endtask

  task automatic mem_done();
    bif.bp_mem_reset_done = 1'b1; tick(); bif.bp_mem_reset_done = 1'b0;
  endtask

  logic [7:0] wa [6] = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56};
  logic       wt [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       wp [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  int         wg [6] = '{2, 0, 1, 5, 0, 3};

  initial begin
    rst_n = 1'b0; stats_clr = 1'b0;
    bif.in_valid = 1'b0; bif.in_addr = '0; bif.in_taken = 1'b0;
    bif.bp_mem_reset_done = 1'b0; bif.bp_pred_ready = 1'b0;
    bif.bp_prediction = 1'b0; bif.bp_training_done = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", 32'(bif.in_ready), 32'd0);
    chk("rst_nd", 32'(bif.bp_new_data), 32'd0);
    chk("rst_addr", 32'(bif.bp_inst_addr), 32'd0);
    chk("rst_truth", 32'(bif.bp_truth), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_total", 32'(total), 32'd0);
    chk("rst_mispred", 32'(mispred), 32'd0);
    chk("rst_terr", 32'(terr), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(bif.in_ready), 32'd1);

    // records queue during INIT but nothing issues
    push(8'h24, 1'b1); push(8'h10, 1'b0); push(8'h33, 1'b1);
    repeat (4) tick();
    chk("init_nd", 32'(bif.bp_new_data), 32'd0);
    chk("init_ready", 32'(bif.in_ready), 32'd1);
    chk("init_busy", 32'(busy), 32'd0);
    mem_done();
    chk("idle_busy", 32'(busy), 32'd0);
    tick();
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_nd", 32'(bif.bp_new_data), 32'd0);
    chk("load_addr", 32'(bif.bp_inst_addr), 32'h24);
    chk("load_truth", 32'(bif.bp_truth), 32'd1);
    tick();
    chk("active_nd", 32'(bif.bp_new_data), 32'd1);
    respond(1'b0, 20, 1'b0);
    wait_nd(); respond(1'b0, 0, 1'b0);
    wait_nd(); respond(1'b1, 3, 1'b0);

    // predictor pulses outside ACTIVE are ignored
    tick();
    drive_resp(1'b1, 1'b1, 1'b1);
    tick();
    chk("ign_total", 32'(total), 32'(exp_tot));
    chk("ign_busy", 32'(busy), 32'd0);

    // fill past DEPTH with one record in flight
    for (int i = 0; i < 5; i++) push(wa[i], wt[i]);
    chk("full_ready", 32'(bif.in_ready), 32'd0);
    bif.in_valid = 1'b1; bif.in_addr = wa[5]; bif.in_taken = wt[5];
    repeat (3) begin tick(); chk("full_hold", 32'(bif.in_ready), 32'd0); end
    wait_nd(); respond(wp[0], wg[0], 1'b0);
    push(wa[5], wt[5]);
    for (int i = 1; i < 6; i++) begin wait_nd(); respond(wp[i], wg[i], 1'b0); end

    // saturate both counters, then one more completion
    for (int i = 0; i < 40 && exp_mis < MAXC; i++) begin
      push(8'h40 + 8'(i), 1'b1); wait_nd(); respond(1'b0, 0, 1'b0);
    end
    push(8'h3F, 1'b1); wait_nd(); respond(1'b0, 1, 1'b0);
    chk("tot_sat", 32'(total), 32'(MAXC));
    chk("mis_sat", 32'(mispred), 32'(MAXC));

    // clear wins over same-cycle completion
    push(8'h61, 1'b1); wait_nd(); respond(1'b0, 0, 1'b1);
    push(8'h62, 1'b0); wait_nd(); respond(1'b1, 2, 1'b0);

    // reset mid-record, then re-wait for memory init
    push(8'h77, 1'b1); wait_nd();
    rst_n = 1'b0; tick();
    chk("mrst_nd", 32'(bif.bp_new_data), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_total", 32'(total), 32'd0);
    chk("mrst_ready", 32'(bif.in_ready), 32'd0);
    chk("mrst_addr", 32'(bif.bp_inst_addr), 32'd0);
    rst_n = 1'b1; sb.delete(); exp_tot = 0; exp_mis = 0;
    tick();
    push(8'h78, 1'b0);
    repeat (5) tick();
    chk("reinit_nd", 32'(bif.bp_new_data), 32'd0);
    mem_done();
    wait_nd(); respond(1'b1, 2, 1'b0);

`ifdef BP_SEQ_TIMEOUT_EN
    push(8'h99, 1'b1); wait_nd();
    repeat (TMO - 1) begin tick(); chk("tmo_hold", 32'(bif.bp_new_data), 32'd1); end
    tick();
    chk("tmo_nd", 32'(bif.bp_new_data), 32'd0);
    chk("tmo_err", 32'(terr), 32'd1);
    chk("tmo_total", 32'(total), 32'(exp_tot));
    push(8'h9A, 1'b0); wait_nd(); respond(1'b0, 1, 1'b0);
    chk("tmo_sticky", 32'(terr), 32'd1);
`else
    chk("terr_off", 32'(terr), 32'd0);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
